// File: rtl/sdr_wbuf_if.sv
// Bus bundle between the user write port, the SDRAM controller write port and sdr_wbuf.
// Handshakes: a word moves on usr_wvld & usr_wrdy and a beat moves on sdr_wr_vld & sdr_wr_ready,
// both sampled on the rising clk edge; valid never depends combinationally on its own ready.
interface sdr_wbuf_if #(
    parameter int DEPTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   usr_wdata;
    logic          usr_wvld;
    logic          usr_wrdy;
    logic [31:0]   usr_addr;
    logic          usr_addr_ld;
    logic          sdr_wr_req;
    logic [31:0]   sdr_waddr;
    logic [15:0]   sdr_wdata_in;
    logic          sdr_wr_vld;
    logic          sdr_wr_ready;
    logic [CW-1:0] fifo_cnt;
    logic          busy;

    modport master (
        output usr_wdata, usr_wvld, usr_addr, usr_addr_ld, sdr_wr_ready,
        input  usr_wrdy, sdr_wr_req, sdr_waddr, sdr_wdata_in, sdr_wr_vld, fifo_cnt, busy
    );

    modport slave (
        input  usr_wdata, usr_wvld, usr_addr, usr_addr_ld, sdr_wr_ready,
        output usr_wrdy, sdr_wr_req, sdr_waddr, sdr_wdata_in, sdr_wr_vld, fifo_cnt, busy
    );
endinterface

// File: rtl/sdr_wbuf.sv
// SDRAM write buffer: collects user words in a FWFT FIFO and issues fixed-length write
// bursts with an auto-incrementing (or reloaded) 25-bit burst address.
module sdr_wbuf #(
    parameter int BURST_LEN = 8,
    parameter int DEPTH     = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    sdr_wbuf_if.slave  bus,
    output logic [1:0] state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] BL_C    = CW'(BURST_LEN);
    localparam logic [BW-1:0] BL_B    = BW'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        NEXT = 2'd3
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [BW-1:0] beat_cnt;
    logic          pend_vld;
    logic [24:0]   pend_addr;
    logic [24:0]   waddr;
    logic          push;
    logic          pop;
    logic          addr_hi_unused;

    // Address bits above the bank field are never stored.
    assign addr_hi_unused = ^bus.usr_addr[31:25];

    assign bus.usr_wrdy     = (cnt < DEPTH_C);
    assign push             = bus.usr_wvld & bus.usr_wrdy;
    assign bus.sdr_wr_vld   = (state == DATA) && (cnt != '0) && (beat_cnt != BL_B);
    assign pop              = bus.sdr_wr_vld & bus.sdr_wr_ready;
    assign bus.sdr_wdata_in = (cnt != '0) ? mem[rd_ptr] : 16'h0000;
    assign bus.sdr_wr_req   = (state == REQ);
    assign bus.busy         = (state != IDLE);
    assign bus.fifo_cnt     = cnt;
    assign bus.sdr_waddr    = {7'b0, waddr};
    assign state_dbg        = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.usr_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            waddr     <= '0;
        end else begin
            // Loads outside IDLE/NEXT are deferred so the burst in flight keeps its address.
            if (bus.usr_addr_ld && (state == REQ || state == DATA)) begin
                pend_vld  <= 1'b1;
                pend_addr <= bus.usr_addr[24:0];
            end
            case (state)
                IDLE: begin
                    if (bus.usr_addr_ld) begin
                        waddr <= bus.usr_addr[24:0];
                    end
                    if (cnt >= BL_C) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == BL_B - BW'(1)) begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    // A load arriving in NEXT itself is the newest one, so it wins.
                    if (bus.usr_addr_ld) begin
                        waddr <= bus.usr_addr[24:0];
                    end else if (pend_vld) begin
                        waddr <= pend_addr;
                    end else begin
                        waddr <= waddr + 25'(BURST_LEN);
                    end
                    pend_vld <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdr_wbuf.sv
// Directed bench for sdr_wbuf (BURST_LEN=8, DEPTH=32): each scenario task drives the bus
// and checks captured requests/beats against hand-computed values.
module tb_sdr_wbuf;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         checks;
    int         errors;

    logic [31:0] req_q[$];
    logic [15:0] beat_q[$];
    logic [31:0] beat_addr_q[$];
    logic [15:0] exp_q[$];

    sdr_wbuf_if #(.DEPTH(32)) bus ();

    sdr_wbuf #(.BURST_LEN(8), .DEPTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture away from the active edge; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.sdr_wr_req === 1'b1) req_q.push_back(bus.sdr_waddr);
            if (bus.sdr_wr_vld === 1'b1 && bus.sdr_wr_ready === 1'b1) begin
                beat_q.push_back(bus.sdr_wdata_in);
                beat_addr_q.push_back(bus.sdr_waddr);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        req_q.delete();
        beat_q.delete();
        beat_addr_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        bus.usr_wvld = 1'b0;
        bus.usr_addr_ld = 1'b0;
        bus.sdr_wr_ready = 1'b0;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        clear_mon();
    endtask

    task automatic pulse_load(input logic [31:0] a);
        bus.usr_addr = a;
        bus.usr_addr_ld = 1'b1;
        tick(1);
        bus.usr_addr_ld = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        logic acc;
        int   t;
        acc = 1'b0;
        t = 0;
        bus.usr_wdata = d;
        bus.usr_wvld = 1'b1;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = bus.usr_wrdy;
            @(posedge clk);
            #1;
            t++;
        end
        bus.usr_wvld = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout word %h not accepted", d);
        end
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (beat_q.size() < n && t < 1000) begin
            tick(1);
            t++;
        end
        checks++;
        if (beat_q.size() < n) begin
            errors++;
            $display("FAIL beat_timeout got %0d beats exp %0d", beat_q.size(), n);
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 200) begin
            tick(1);
            t++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout busy stuck at %b", bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.usr_wdata = '0;
        bus.usr_wvld = 1'b0;
        bus.usr_addr = '0;
        bus.usr_addr_ld = 1'b0;
        bus.sdr_wr_ready = 1'b0;
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({bus.sdr_wr_req, bus.sdr_wr_vld, bus.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got req/vld/busy %b exp 000", {bus.sdr_wr_req, bus.sdr_wr_vld, bus.busy});
        end
        checks++;
        if (bus.sdr_wdata_in !== 16'h0 || bus.sdr_waddr !== 32'h0 || bus.fifo_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_data got wdata %h addr %h cnt %0d exp 0", bus.sdr_wdata_in, bus.sdr_waddr, bus.fifo_cnt);
        end
        rst_n = 1'b1;
        tick(1);
        checks++;
        if (bus.usr_wrdy !== 1'b1 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_release got wrdy %b state %0d exp 1 0", bus.usr_wrdy, state_dbg);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        bus.sdr_wr_ready = 1'b1;
        pulse_load(32'h0000_0100);
        for (int i = 0; i < 8; i++) begin
            push_word(16'(32'h1000 + i));
            exp_q.push_back(16'(32'h1000 + i));
        end
        wait_beats(8);
        wait_idle();
        checks++;
        if (req_q.size() !== 1 || req_q[0] !== 32'h100) begin
            errors++;
            $display("FAIL single_req got %0d reqs first %h exp 1 at 00000100", req_q.size(), req_q[0]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i] || beat_addr_q[i] !== 32'h100) begin
                errors++;
                $display("FAIL single_beat%0d got %h@%h exp %h@00000100", i, beat_q[i], beat_addr_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.sdr_waddr !== 32'h108 || bus.fifo_cnt !== 6'd0) begin
            errors++;
            $display("FAIL single_after got addr %h cnt %0d exp 00000108 0", bus.sdr_waddr, bus.fifo_cnt);
        end
    endtask

    task automatic test_below_threshold();
        do_reset();
        bus.sdr_wr_ready = 1'b1;
        for (int i = 0; i < 7; i++) push_word(16'(32'h2000 + i));
        tick(20);
        checks++;
        if (req_q.size() !== 0 || bus.fifo_cnt !== 6'd7 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL below_thresh got reqs %0d cnt %0d busy %b exp 0 7 0", req_q.size(), bus.fifo_cnt, bus.busy);
        end
        checks++;
        if (bus.sdr_wdata_in !== 16'h2000 || bus.sdr_wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL below_head got wdata %h vld %b exp 2000 0", bus.sdr_wdata_in, bus.sdr_wr_vld);
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        bus.sdr_wr_ready = 1'b0;
        for (int i = 0; i < 32; i++) push_word(16'(32'h1000 + i));
        tick(1);
        checks++;
        if (bus.fifo_cnt !== 6'd32 || bus.usr_wrdy !== 1'b0) begin
            errors++;
            $display("FAIL full_level got cnt %0d wrdy %b exp 32 0", bus.fifo_cnt, bus.usr_wrdy);
        end
        checks++;
        if (bus.sdr_wr_vld !== 1'b1 || bus.sdr_wdata_in !== 16'h1000 || req_q.size() !== 1) begin
            errors++;
            $display("FAIL full_hold got vld %b wdata %h reqs %0d exp 1 1000 1", bus.sdr_wr_vld, bus.sdr_wdata_in, req_q.size());
        end
        bus.sdr_wr_ready = 1'b1;
        for (int i = 32; i < 40; i++) push_word(16'(32'h1000 + i));
        wait_beats(40);
        wait_idle();
        checks++;
        if (req_q.size() !== 5) begin
            errors++;
            $display("FAIL full_reqs got %0d exp 5", req_q.size());
        end
        for (int b = 0; b < 5; b++) begin
            checks++;
            if (req_q[b] !== 32'(b * 8)) begin
                errors++;
                $display("FAIL full_req%0d got %h exp %h", b, req_q[b], 32'(b * 8));
            end
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (beat_q[i] !== 16'(32'h1000 + i) || beat_addr_q[i] !== 32'((i / 8) * 8)) begin
                errors++;
                $display("FAIL full_beat%0d got %h@%h exp %h@%h", i, beat_q[i], beat_addr_q[i], 16'(32'h1000 + i), 32'((i / 8) * 8));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.sdr_wr_ready = 1'b1;
        pulse_load(32'h01FF_FFF8);
        for (int i = 0; i < 16; i++) push_word(16'(32'h3000 + i));
        wait_beats(16);
        wait_idle();
        checks++;
        if (req_q.size() !== 2 || req_q[0] !== 32'h01FF_FFF8 || req_q[1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_reqs got %0d reqs %h %h exp 2 01fffff8 00000000", req_q.size(), req_q[0], req_q[1]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beat_q[i] !== 16'(32'h3000 + i)) begin
                errors++;
                $display("FAIL wrap_beat%0d got %h exp %h", i, beat_q[i], 16'(32'h3000 + i));
            end
        end
        checks++;
        if (bus.sdr_waddr !== 32'h8) begin
            errors++;
            $display("FAIL wrap_after got %h exp 00000008", bus.sdr_waddr);
        end
    endtask

    task automatic test_pending_load();
        int t;
        do_reset();
        bus.sdr_wr_ready = 1'b0;
        pulse_load(32'h0000_0200);
        for (int i = 0; i < 8; i++) push_word(16'(32'h5000 + i));
        t = 0;
        while (state_dbg !== 2'd2 && t < 50) begin
            tick(1);
            t++;
        end
        checks++;
        if (state_dbg !== 2'd2) begin
            errors++;
            $display("FAIL pend_data_state got %0d exp 2", state_dbg);
        end
        pulse_load(32'hFE00_4000);
        tick(1);
        checks++;
        if (bus.sdr_waddr !== 32'h200) begin
            errors++;
            $display("FAIL pend_hold got %h exp 00000200", bus.sdr_waddr);
        end
        bus.sdr_wr_ready = 1'b1;
        for (int i = 8; i < 16; i++) push_word(16'(32'h5000 + i));
        wait_beats(16);
        wait_idle();
        checks++;
        if (req_q.size() !== 2 || req_q[0] !== 32'h200 || req_q[1] !== 32'h4000) begin
            errors++;
            $display("FAIL pend_reqs got %0d reqs %h %h exp 2 00000200 00004000", req_q.size(), req_q[0], req_q[1]);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (beat_q[i] !== 16'(32'h5000 + i) || beat_addr_q[i] !== ((i < 8) ? 32'h200 : 32'h4000)) begin
                errors++;
                $display("FAIL pend_beat%0d got %h@%h exp %h", i, beat_q[i], beat_addr_q[i], 16'(32'h5000 + i));
            end
        end
        checks++;
        if (bus.sdr_waddr !== 32'h4008) begin
            errors++;
            $display("FAIL pend_after got %h exp 00004008", bus.sdr_waddr);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.sdr_wr_ready = 1'b1;
        pulse_load(32'h0000_0040);
        for (int i = 0; i < 8; i++) push_word(16'(32'h6000 + i));
        wait_beats(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (beat_q.size() !== 3) begin
            errors++;
            $display("FAIL rst_mid_beats got %0d exp 3", beat_q.size());
        end
        checks++;
        if ({bus.sdr_wr_req, bus.sdr_wr_vld, bus.busy} !== 3'b000 || bus.sdr_wdata_in !== 16'h0 ||
            bus.fifo_cnt !== 6'd0 || bus.sdr_waddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outs got ctl %b wdata %h cnt %0d addr %h exp 000 0 0 0",
                     {bus.sdr_wr_req, bus.sdr_wr_vld, bus.busy}, bus.sdr_wdata_in, bus.fifo_cnt, bus.sdr_waddr);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_mon();
        checks++;
        if (bus.usr_wrdy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wrdy got %b exp 1", bus.usr_wrdy);
        end
        tick(20);
        for (int i = 0; i < 7; i++) push_word(16'(32'h7000 + i));
        tick(10);
        checks++;
        if (req_q.size() !== 0 || beat_q.size() !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet got reqs %0d beats %0d exp 0 0", req_q.size(), beat_q.size());
        end
        push_word(16'h7007);
        wait_beats(8);
        wait_idle();
        checks++;
        if (req_q.size() !== 1 || req_q[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_req got %0d reqs %h exp 1 00000000", req_q.size(), req_q[0]);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (beat_q[i] !== 16'(32'h7000 + i)) begin
                errors++;
                $display("FAIL rst_mid_beat%0d got %h exp %h", i, beat_q[i], 16'(32'h7000 + i));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_burst();
        test_below_threshold();
        test_full_backpressure();
        test_wrap();
        test_pending_load();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
